// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the fast-path result
//   (requester A) and multi-cycle load returns (requester B). The winner is
//   registered onto the port one cycle after its handshake. A pending-load
//   scoreboard (busy) tracks outstanding loads so decode can stall on RAW
//   hazards.
//
//   Build option: WB_STARVE_GUARD_EN
//     defined   - a 4-bit starve counter forces A to win after STARVE_LIMIT
//                 consecutive lost arbitrations.
//     undefined - strict priority, B always wins when both are valid.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   a_valid/a_rd/a_data   fast-path write request
//   a_ready               A accepted this cycle (combinational)
//   b_valid/b_rd/b_data   load-return write request
//   b_ready               B accepted this cycle (combinational)
//   wb_stall              freezes the port, no handshake completes
//   issue_valid/issue_rd  load issued this cycle and its destination
//   busy                  bit n set = load to xn outstanding
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            wb_stall,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    logic            force_a;
    logic            a_fire;
    logic            b_fire;
    logic            fire;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     busy_next;

`ifdef WB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_a = (starve_cnt == 4'(STARVE_LIMIT));

    // Counts lost arbitrations only while A is actually waiting; any cycle
    // where A is absent or wins resets the run. Stall freezes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!wb_stall) begin
            if (a_fire || !a_valid) begin
                starve_cnt <= '0;
            end else if (b_fire && (starve_cnt != 4'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign force_a = 1'b0;
`endif

    // Ready depends only on valids, stall and the counter, never on data.
    assign a_ready = !wb_stall && a_valid && (!b_valid || force_a);
    assign b_ready = !wb_stall && b_valid && !(a_valid && force_a);

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    assign fire   = a_fire || b_fire;

    assign win_rd   = b_fire ? b_rd   : a_rd;
    assign win_data = b_fire ? b_data : a_data;

    // Writes to x0 complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= fire && (win_rd != 5'd0);
            if (fire) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

    // Set is applied after clear so an issue and a return to the same rd in
    // one cycle leave the register marked busy.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (issue_valid) begin
            set_mask = 32'd1 << issue_rd;
        end
        if (b_fire) begin
            clr_mask = 32'd1 << b_rd;
        end
        busy_next = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(a_ready && b_ready));

    a_limit_range: assert property (@(posedge clk)
        (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a reference model running on the
// falling edge predicts ready and pushes the expected write-port contents,
// which are popped and compared one cycle later. Directed tests add explicit
// checks for reset, contention, x0 suppression, scoreboard, stall and
// back-to-back writes, followed by constrained random traffic.
module tb_wb_port_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 3;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            wb_stall;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [31:0]     busy;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    wb_port_arbiter #(
        .XLEN        (XLEN),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .wb_stall   (wb_stall),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .busy       (busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t             exp_q[$];
    int unsigned     m_cnt;
    logic [31:0]     m_busy;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;

    // Reference model and scoreboard.
    always @(negedge clk) begin
        wr_t             e;
        logic            m_force;
        logic            ea;
        logic            eb;
        logic            mfire;
        logic [4:0]      wrd;
        logic [XLEN-1:0] wdat;
        logic [31:0]     setm;
        logic [31:0]     clrm;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt  = 0;
            m_busy = '0;
            m_addr = '0;
            m_data = '0;
            check("rst_rf_we",    64'(rf_we),    64'(0));
            check("rst_rf_waddr", 64'(rf_waddr), 64'(0));
            check("rst_rf_wdata", 64'(rf_wdata), 64'(0));
            check("rst_busy",     64'(busy),     64'(0));
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_rf_we",    64'(rf_we),    64'(e.we));
                check("sb_rf_waddr", 64'(rf_waddr), 64'(e.addr));
                check("sb_rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
            check("sb_busy", 64'(busy), 64'(m_busy));

            m_force = GUARD && (m_cnt == LIMIT);
            ea = !wb_stall && a_valid && (!b_valid || m_force);
            eb = !wb_stall && b_valid && !(a_valid && m_force);
            check("sb_a_ready", 64'(a_ready), 64'(ea));
            check("sb_b_ready", 64'(b_ready), 64'(eb));

            mfire = ea || eb;
            wrd   = eb ? b_rd : a_rd;
            wdat  = eb ? b_data : a_data;
            if (mfire) begin
                m_addr = wrd;
                m_data = wdat;
            end
            e.we   = mfire && (wrd != 5'd0);
            e.addr = m_addr;
            e.data = m_data;
            exp_q.push_back(e);

            if (!wb_stall) begin
                if (ea || !a_valid) begin
                    m_cnt = 0;
                end else if (eb && (m_cnt < LIMIT)) begin
                    m_cnt = m_cnt + 1;
                end
            end

            setm = issue_valid ? (32'd1 << issue_rd) : 32'd0;
            clrm = eb ? (32'd1 << b_rd) : 32'd0;
            m_busy = ((m_busy & ~clrm) | setm) & 32'hFFFF_FFFE;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] exp_cont;
        logic       fa;
        logic       fb;

        rst_n       = 1'b0;
        a_valid     = 1'b1;
        a_rd        = 5'd5;
        a_data      = 32'h0000_1234;
        b_valid     = 1'b0;
        b_rd        = '0;
        b_data      = '0;
        wb_stall    = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;

        // Reset release, first A write, then reset in the middle of traffic.
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        check("rst_first_we",    64'(rf_we),    64'(1));
        check("rst_first_waddr", 64'(rf_waddr), 64'(5));
        check("rst_first_wdata", 64'(rf_wdata), 64'(32'h0000_1234));
        check("rst_first_busy9", 64'(busy[9]),  64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we",   64'(rf_we), 64'(0));
        check("midrst_busy", 64'(busy),  64'(0));
        a_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Contention: both held.
        exp_cont = GUARD ? 6'b11_0111 : 6'b11_1111;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAAAA_0003;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hBBBB_0004;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("cont_b_ready%0d", k), 64'(b_ready), 64'(exp_cont[k]));
            check($sformatf("cont_a_ready%0d", k), 64'(a_ready), 64'(!exp_cont[k]));
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        // x0 suppression.
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
        #1;
        check("x0_b_ready", 64'(b_ready), 64'(1));
        tick();
        b_valid = 1'b0;
        check("x0_rf_we", 64'(rf_we), 64'(0));
        check("x0_busy",  64'(busy),  64'(0));
        tick();

        // Scoreboard set/clear.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set7", 64'(busy[7]), 64'(1));
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0077;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        b_valid = 1'b0;
        issue_valid = 1'b0;
        check("sb_setwins7", 64'(busy[7]),  64'(1));
        check("sb_ld7_we",   64'(rf_we),    64'(1));
        check("sb_ld7_addr", 64'(rf_waddr), 64'(7));
        tick();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0078;
        tick();
        b_valid = 1'b0;
        check("sb_clr7", 64'(busy[7]), 64'(0));
        tick();

        // Stall with counter at 2.
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAAAA_0013;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hBBBB_0014;
        tick();
        tick();
        wb_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("stall_a_ready%0d", k), 64'(a_ready), 64'(0));
            check($sformatf("stall_b_ready%0d", k), 64'(b_ready), 64'(0));
            tick();
            check($sformatf("stall_rf_we%0d", k), 64'(rf_we), 64'(0));
        end
        wb_stall = 1'b0;
        #1;
        check("stall_rel_b", 64'(b_ready), 64'(1));
        tick();
        #1;
        check("stall_then_a", 64'(a_ready), 64'(GUARD));
        check("stall_then_b", 64'(b_ready), 64'(!GUARD));
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        // Back-to-back A writes.
        a_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_rd   = 5'(i);
            a_data = 32'h0000_0100 + 32'(i);
            tick();
            check($sformatf("b2b_we%0d", i),    64'(rf_we),    64'(1));
            check($sformatf("b2b_waddr%0d", i), 64'(rf_waddr), 64'(i));
            check($sformatf("b2b_wdata%0d", i), 64'(rf_wdata), 64'(32'h0000_0100 + 32'(i)));
        end
        a_valid = 1'b0;
        tick();
        check("b2b_end_we",    64'(rf_we),    64'(0));
        check("b2b_hold_addr", 64'(rf_waddr), 64'(4));

        // Random traffic; requests hold until they fire.
        for (int c = 0; c < 300; c++) begin
            #2;
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            tick();
            if (!a_valid || fa) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || fb) begin
                b_valid = 1'($urandom_range(0, 1));
                b_rd    = 5'($urandom);
                b_data  = $urandom;
            end
            wb_stall    = ($urandom_range(0, 3) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom);
        end
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        wb_stall    = 1'b0;
        issue_valid = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
